// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared constants and fetch FSM encodings for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_ST = 2'd0,
    HOLD_ST  = 2'd1,
    FLUSH_ST = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner; fetches words from PMEM (req/ack) and hands them to
//               decode (valid/ready), honouring execute-stage redirects.
//               Optional macro MISALIGN_TRAP_EN adds the fetch_misaligned trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                pmem_req,
  output logic [PC_WIDTH-1:0] pmem_addr,
  input  logic                pmem_ack,
  input  logic [31:0]         pmem_rdata,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                fetch_misaligned
`endif
);

  fetch_state_t        r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next;
  logic [PC_WIDTH-1:0] w_target, w_addr_next, w_instr_pc_next;
  logic [31:0]         w_instr_next;
  logic                w_valid_next, w_req_next;
  logic                w_ack, w_tgt_mis, w_halted, w_mis_next;

  // An ack only counts against a request we actually have outstanding.
  assign w_ack = pmem_ack & pmem_req;

`ifdef MISALIGN_TRAP_EN
  assign w_target  = redirect_pc;
  assign w_tgt_mis = |redirect_pc[1:0];
  assign w_halted  = fetch_misaligned;
`else
  assign w_target  = redirect_pc & ~PC_WIDTH'(3);
  assign w_tgt_mis = 1'b0;
  assign w_halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH_ST;
      r_pc        <= RESET_PC;
      pmem_req    <= 1'b0;
      pmem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      pmem_req    <= w_req_next;
      pmem_addr   <= w_addr_next;
      instr       <= w_instr_next;
      instr_pc    <= w_instr_pc_next;
      instr_valid <= w_valid_next;
`ifdef MISALIGN_TRAP_EN
      fetch_misaligned <= w_mis_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = instr;
    w_instr_pc_next = instr_pc;
    w_valid_next    = instr_valid;
    w_mis_next      = w_halted;
    w_req_next      = 1'b0;
    w_addr_next     = pmem_addr;

    case (r_state)
      FETCH_ST: begin
        if (redirect_valid) begin
          w_pc_next  = w_target;
          w_mis_next = w_tgt_mis;
          // A request still waiting for its ack cannot be withdrawn.
          w_state_next = (pmem_req && !pmem_ack) ? FLUSH_ST : FETCH_ST;
        end else if (w_ack) begin
          w_instr_next    = pmem_rdata;
          w_instr_pc_next = r_pc;
          w_valid_next    = 1'b1;
          w_pc_next       = r_pc + PC_WIDTH'(INSTR_BYTES);
          w_state_next    = HOLD_ST;
        end
      end
      HOLD_ST: begin
        if (redirect_valid || instr_ready) begin
          w_valid_next = 1'b0;
          w_instr_next = NOP_INSTR;
          w_state_next = FETCH_ST;
        end
        if (redirect_valid) begin
          w_pc_next  = w_target;
          w_mis_next = w_tgt_mis;
        end
      end
      FLUSH_ST: begin
        if (redirect_valid) begin
          w_pc_next  = w_target;
          w_mis_next = w_tgt_mis;
        end
        if (w_ack) w_state_next = FETCH_ST;
      end
      default: w_state_next = FETCH_ST;
    endcase

    case (w_state_next)
      FLUSH_ST: w_req_next = 1'b1;
      FETCH_ST: begin
        // Leaving FLUSH forces one idle cycle on pmem_req.
        w_req_next  = !w_mis_next && (r_state != FLUSH_ST);
        w_addr_next = w_pc_next;
      end
      default:  w_req_next = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed + random bench with a PMEM model and an in-order
//               instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmem_req, pmem_ack = 1'b0;
  logic [31:0] pmem_addr, pmem_rdata = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pmem_req       (pmem_req),
    .pmem_addr      (pmem_addr),
    .pmem_ack       (pmem_ack),
    .pmem_rdata     (pmem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0093;
  endfunction

  // PMEM model: random (or forced) wait states per request, single ack.
  int  next_delay = 0;
  bit  rand_delay = 1'b0;
  bit  busy = 1'b0;
  int  wait_left = 0;

  task automatic pmem_model();
    if (pmem_req) begin
      if (!busy) begin
        busy = 1'b1;
        wait_left = rand_delay ? int'($urandom_range(0, 3)) : next_delay;
      end
      if (wait_left == 0) begin
        pmem_ack   = 1'b1;
        pmem_rdata = mem_word(pmem_addr);
        busy       = 1'b0;
      end else begin
        pmem_ack   = 1'b0;
        pmem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      pmem_ack   = 1'b0;
      pmem_rdata = $urandom;
      busy       = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pmem_model();
  endtask

  // Reference model: the delivered stream is sequential from the last redirect.
  logic [31:0] exp_pc = '0;
  bit          exp_mis = 1'b0;
  bit          prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  int          stall = 0, max_stall = 0;
  int          delivered = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc   = '0;
      exp_mis  = 1'b0;
      prev_req = 1'b0;
      stall    = 0;
    end else begin
      check_eq("nop_when_idle", instr_valid ? NOP : instr, NOP);
      if (prev_req && !prev_ack) begin
        check_eq("req_held", {31'b0, pmem_req}, 32'h1);
        check_eq("addr_stable", pmem_addr, prev_addr);
      end
`ifdef MISALIGN_TRAP_EN
      check_eq("misaligned_flag", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
      if (exp_mis) check_eq("no_instr_when_trapped", {31'b0, instr_valid}, 32'h0);
`endif
      if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
        exp_pc  = redirect_pc;
        exp_mis = (redirect_pc[1:0] != 2'b00);
`else
        exp_pc  = redirect_pc & ~32'h3;
`endif
      end else if (instr_valid && instr_ready) begin
        check_eq("deliver_pc", instr_pc, exp_pc);
        check_eq("deliver_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
        stall = 0;
      end
      if (exp_mis) stall = 0;
      else stall++;
      if (stall > max_stall) max_stall = stall;
      prev_req  = pmem_req;
      prev_ack  = pmem_ack;
      prev_addr = pmem_addr;
    end
  end

  initial begin
    int guard;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'b0, pmem_req}, 32'h0);
    check_eq("rst_addr", pmem_addr, 32'h0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);

    // First fetch: req at edge 1, valid at edge 2
    @(posedge clk); #1; rst_n = 1'b1;
    next_delay = 0;
    tick();
    check_eq("first_req", {31'b0, pmem_req}, 32'h1);
    check_eq("first_addr", pmem_addr, 32'h0);
    tick();
    check_eq("first_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("first_instr", instr, 32'h0000_0093);
    check_eq("first_ipc", instr_pc, 32'h0);

    // Back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", {31'b0, instr_valid}, 32'h1);
      check_eq("bp_instr", instr, 32'h0000_0093);
      check_eq("bp_ipc", instr_pc, 32'h0);
      check_eq("bp_req", {31'b0, pmem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    next_delay  = 3;
    tick();
    instr_ready = 1'b0;
    check_eq("after_bp_addr", pmem_addr, 32'h4);
    check_eq("after_bp_req", {31'b0, pmem_req}, 32'h1);

    // Redirect in the first wait cycle of a slow fetch
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    next_delay = 0;
    guard = 0;
    while (!pmem_ack && guard < 10) begin
      check_eq("flush_addr", pmem_addr, 32'h4);
      check_eq("flush_valid", {31'b0, instr_valid}, 32'h0);
      tick();
      guard++;
    end
    check_eq("flush_ack_seen", {31'b0, pmem_ack}, 32'h1);
    tick();
    check_eq("flush_drop", {31'b0, pmem_req}, 32'h0);
    check_eq("flush_no_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("redir_addr", pmem_addr, 32'h100);
    check_eq("redir_req", {31'b0, pmem_req}, 32'h1);

    // Redirect coincident with ack
    check_eq("coinc_ack", {31'b0, pmem_ack}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check_eq("coinc_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("coinc_addr", pmem_addr, 32'h300);
    tick();
    check_eq("hold_ipc", instr_pc, 32'h300);
    // Redirect while holding, ready also high: held instruction killed
    redirect_valid = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    check_eq("hold_kill_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("hold_kill_addr", pmem_addr, 32'h200);
    tick();
    check_eq("new_path_ipc", instr_pc, 32'h200);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_addr", pmem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check_eq("wrap_next_addr", pmem_addr, 32'h0);

`ifdef MISALIGN_TRAP_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    check_eq("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
    check_eq("mis_req", {31'b0, pmem_req}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_clear", {31'b0, fetch_misaligned}, 32'h0);
    check_eq("mis_restart_addr", pmem_addr, 32'h104);
`endif

    // Randomized phase
    rand_delay = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: redirect_pc = $urandom & 32'h0000_FFFF;
      endcase
      if ($urandom_range(0, 9) != 0) redirect_pc[1:0] = 2'b00;
    end
    instr_ready = 1'b0; redirect_valid = 1'b0;
    tick();
    check_eq("stream_progress", {31'b0, delivered > 50}, 32'h1);
    check_eq("liveness", {31'b0, max_stall < 400}, 32'h1);

    // Asynchronous reset mid-operation
    #2; rst_n = 1'b0;
    #1;
    check_eq("async_rst_req", {31'b0, pmem_req}, 32'h0);
    check_eq("async_rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("async_rst_addr", pmem_addr, 32'h0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
